// File: rtl/fan_button_conditioner.sv
// Conditions the raw UP/DOWN fan buttons into clean one-cycle step pulses:
// 2-flop synchronisers, per-button debounce, mutual-exclusion lockout and hold-to-repeat.
module fan_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic up_btn,
  input  logic down_btn,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, UP_HELD, DOWN_HELD, LOCK} state_t;

  // Bit 0 is the UP button, bit 1 the DOWN button throughout.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [DB_W-1:0] db_cnt [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      // NOTE: the debounce counters are a tiny register array, not a RAM, so
      // they are cleared explicitly; a button held across reset re-debounces.
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1 value,
      // which is what makes this a two-stage shift rather than a wire.
      sync1 <= {down_btn, up_btn};
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          level[b]  <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  assign up_level   = level[0];
  assign down_level = level[1];

  state_t           state, state_next;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_next;
  logic             rpt_periodic, rpt_periodic_next;
  logic             up_pulse_next, down_pulse_next;
  logic [RPT_W-1:0] rpt_tick;
  logic             rpt_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
      up_pulse     <= 1'b0;
      down_pulse   <= 1'b0;
    end else begin
      state        <= state_next;
      rpt_cnt      <= rpt_cnt_next;
      rpt_periodic <= rpt_periodic_next;
      up_pulse     <= up_pulse_next;
      down_pulse   <= down_pulse_next;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (level[0] && level[1])  state_next = LOCK;
        else if (level[0])         state_next = UP_HELD;
        else if (level[1])         state_next = DOWN_HELD;
      end
      UP_HELD: begin
        if (level[1])              state_next = LOCK;
        else if (!level[0])        state_next = IDLE;
      end
      DOWN_HELD: begin
        if (level[0])              state_next = LOCK;
        else if (!level[1])        state_next = IDLE;
      end
      LOCK: begin
        if (!level[0] && !level[1]) state_next = IDLE;
      end
      default:                     state_next = IDLE;
    endcase
  end

  // The repeat counter measures from the last pulse; the first target is the
  // initial delay, every later one is the period.
  assign rpt_tick = rpt_cnt + RPT_W'(1);
  assign rpt_hit  = (REPEAT_EN != 0) &&
                    (rpt_tick == (rpt_periodic ? RPT_PERIOD : RPT_DELAY));

  always_comb begin
    up_pulse_next     = 1'b0;
    down_pulse_next   = 1'b0;
    rpt_cnt_next      = rpt_cnt;
    rpt_periodic_next = rpt_periodic;
    case (state)
      IDLE: begin
        rpt_cnt_next      = '0;
        rpt_periodic_next = 1'b0;
        up_pulse_next     = (state_next == UP_HELD);
        down_pulse_next   = (state_next == DOWN_HELD);
      end
      UP_HELD, DOWN_HELD: begin
        if (state_next == state && REPEAT_EN != 0) begin
          if (rpt_hit) begin
            rpt_cnt_next      = '0;
            rpt_periodic_next = 1'b1;
            up_pulse_next     = (state == UP_HELD);
            down_pulse_next   = (state == DOWN_HELD);
          end else begin
            rpt_cnt_next = rpt_tick;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fan_button_conditioner.sv
// Randomised and directed bench for fan_button_conditioner: a window-based reference
// model predicts pulses into per-instance queues that a negedge monitor drains.
module tb_fan_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       reset, up_btn, down_btn;
  logic [1:0] up_p, dn_p, up_l, dn_l;

  // Instance 0 repeats while held, instance 1 gives one pulse per press.
  fan_button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_rep (
    .clk(clk), .reset(reset), .up_btn(up_btn), .down_btn(down_btn),
    .up_pulse(up_p[0]), .down_pulse(dn_p[0]), .up_level(up_l[0]), .down_level(dn_l[0])
  );

  fan_button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_once (
    .clk(clk), .reset(reset), .up_btn(up_btn), .down_btn(down_btn),
    .up_pulse(up_p[1]), .down_pulse(dn_p[1]), .up_level(up_l[1]), .down_level(dn_l[1])
  );

  always #5 clk = ~clk;

  typedef struct { int at_edge; bit is_up; } ev_t;
  typedef enum {M_IDLE, M_UP, M_DN, M_LOCK} mmode_t;

  ev_t    exp_q [2][$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     edge_no = 0;

  // Reference model state: raw samples delayed two edges, a window of the
  // last DB debounce samples per button, and a press-tracking mode per instance.
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_lvl [2];
  logic [DB-1:0] m_hist [2];
  int          m_nvalid [2];
  mmode_t      m_mode [2];
  int          m_t0 [2];

  int cnt_up [2], cnt_dn [2], first_up [2], first_dn [2], last_up [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic push_ev(input int i, input bit is_up);
    ev_t ev;
    ev.at_edge = edge_no;
    ev.is_up   = is_up;
    exp_q[i].push_back(ev);
  endtask

  // Press semantics: a lone debounced press pulses at once; while it stays the
  // only one held, repeats fall RD edges after that pulse and every RP after.
  task automatic model_arb(input int i);
    bit lu, ld;
    int d;
    lu = m_lvl[0];
    ld = m_lvl[1];
    case (m_mode[i])
      M_IDLE: begin
        if (lu && ld)  m_mode[i] = M_LOCK;
        else if (lu) begin push_ev(i, 1'b1); m_mode[i] = M_UP; m_t0[i] = edge_no; end
        else if (ld) begin push_ev(i, 1'b0); m_mode[i] = M_DN; m_t0[i] = edge_no; end
      end
      M_UP, M_DN: begin
        if ((m_mode[i] == M_UP) ? ld : lu)        m_mode[i] = M_LOCK;
        else if (!((m_mode[i] == M_UP) ? lu : ld)) m_mode[i] = M_IDLE;
        else if (i == 0) begin
          d = edge_no - m_t0[i];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) push_ev(i, m_mode[i] == M_UP);
        end
      end
      M_LOCK: if (!lu && !ld) m_mode[i] = M_IDLE;
      default: m_mode[i] = M_IDLE;
    endcase
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0;
        m_hist[b] = '0; m_nvalid[b] = 0; m_mode[b] = M_IDLE;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_arb(i);
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
        if (m_nvalid[b] < DB) m_nvalid[b]++;
        if (m_nvalid[b] == DB && m_hist[b] == {DB{~m_lvl[b]}}) m_lvl[b] = ~m_lvl[b];
        m_s2[b] = m_s1[b];
      end
      m_s1[0] = up_btn;
      m_s1[1] = down_btn;
    end
  end

  always @(negedge clk) begin : monitor
    ev_t ev;
    bit  eu, ed;
    if (edge_no > 0) begin
      for (int i = 0; i < 2; i++) begin
        eu = 1'b0;
        ed = 1'b0;
        if (exp_q[i].size() > 0 && exp_q[i][0].at_edge == edge_no) begin
          ev = exp_q[i].pop_front();
          eu = ev.is_up;
          ed = !ev.is_up;
        end
        if (eu || ed || up_p[i] !== 1'b0 || dn_p[i] !== 1'b0) begin
          check($sformatf("up_pulse[%0d]", i), up_p[i], eu);
          check($sformatf("down_pulse[%0d]", i), dn_p[i], ed);
        end
        check($sformatf("up_level[%0d]", i), up_l[i], m_lvl[0]);
        check($sformatf("down_level[%0d]", i), dn_l[i], m_lvl[1]);
        if (up_p[i] === 1'b1) begin
          if (cnt_up[i] == 0) first_up[i] = edge_no;
          last_up[i] = edge_no;
          cnt_up[i]++;
        end
        if (dn_p[i] === 1'b1) begin
          if (cnt_dn[i] == 0) first_dn[i] = edge_no;
          cnt_dn[i]++;
        end
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_up[i] = 0; cnt_dn[i] = 0; first_up[i] = -1; first_dn[i] = -1; last_up[i] = -1;
    end
  endtask

  task automatic expect_counts(input string tag, input int u0, input int d0,
                               input int u1, input int d1);
    check({tag, " up_count[0]"}, cnt_up[0], u0);
    check({tag, " down_count[0]"}, cnt_dn[0], d0);
    check({tag, " up_count[1]"}, cnt_up[1], u1);
    check({tag, " down_count[1]"}, cnt_dn[1], d1);
  endtask

  // Called at a negedge; the values are sampled by the next n rising edges.
  task automatic drive(input logic u, input logic d, input int n);
    up_btn   = u;
    down_btn = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    reset = 1'b1; up_btn = 1'b1; down_btn = 1'b1;
    clear_counts();

    // Reset held three edges with both buttons pressed.
    repeat (3) begin
      @(negedge clk);
      check("reset outputs", {up_p, dn_p, up_l, dn_l}, 8'h00);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("levels before edge 6", {up_l, dn_l}, 4'b0000);
    @(negedge clk);
    check("levels at edge 6", {up_l, dn_l}, 4'b1111);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b0, 12);
    expect_counts("both-at-reset", 0, 0, 0, 0);

    // Clean hold: 30 sampled-high edges.
    clear_counts();
    base = edge_no;
    drive(1'b1, 1'b0, 30);
    drive(1'b0, 1'b0, 15);
    expect_counts("clean hold", 5, 0, 1, 0);
    check("clean hold latency", first_up[0] - base, DB + 3);

    // Glitch one cycle shorter than the debounce window.
    clear_counts();
    drive(1'b1, 1'b0, DB - 1);
    drive(1'b0, 1'b0, 12);
    expect_counts("glitch", 0, 0, 0, 0);

    // Bounce then a 20-cycle stable hold.
    clear_counts();
    for (int k = 0; k < 10; k++) drive(1'b0, (k % 2 == 0), 1);
    base = edge_no;
    drive(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0, 15);
    expect_counts("bounce", 0, 3, 0, 1);
    check("bounce latency", first_dn[1] - base, DB + 3);

    // Lockout: second button joins, first released alone, then a fresh press.
    clear_counts();
    drive(1'b1, 1'b0, 9);
    drive(1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 15);
    drive(1'b0, 1'b0, 12);
    expect_counts("lockout", 1, 0, 1, 0);
    base = edge_no;
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 12);
    expect_counts("after lockout", 2, 0, 2, 0);
    check("after lockout latency", last_up[1] - base, DB + 3);

    // One-cycle reset while a press is being held.
    clear_counts();
    drive(1'b1, 1'b0, 12);
    reset = 1'b1;
    @(negedge clk);
    check("mid-hold reset outputs", {up_p, dn_p, up_l, dn_l}, 8'h00);
    reset = 1'b0;
    base = edge_no;
    drive(1'b1, 1'b0, 15);
    drive(1'b0, 1'b0, 12);
    expect_counts("reset mid-hold", 3, 0, 2, 0);
    check("reset mid-hold latency", last_up[1] - base, DB + 3);

    // Random button activity with occasional resets.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 25));
    end
    drive(1'b0, 1'b0, 20);

    check("queue[0] drained", exp_q[0].size(), 0);
    check("queue[1] drained", exp_q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
